// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO built around one SRAM2RW16x16 dual-port macro.
// Port 1 only writes, port 2 only reads, and the port-2 output latch acts as the head register.
module sram_fifo_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] sram_a1,
   output logic [ADDR_W-1:0] sram_a2,
   output logic              sram_ce1,
   output logic              sram_ce2,
   output logic              sram_csb1,
   output logic              sram_csb2,
   output logic              sram_web1,
   output logic              sram_web2,
   output logic              sram_oeb1,
   output logic              sram_oeb2,
   output logic [DATA_W-1:0] sram_i1,
   input  logic [DATA_W-1:0] sram_o2
);

   localparam logic [ADDR_W:0] MEM_FULL = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   mem_cnt;
   logic              head_vld;

   logic wr_fire;
   logic rd_issue;
   logic pop;

   assign in_ready = (mem_cnt < MEM_FULL) && !flush;
   // Write strobe is also gated by rst_n so a producer holding in_valid through reset cannot touch the macro.
   assign wr_fire  = in_valid && in_ready && rst_n;
   assign pop      = head_vld && out_ready;
   // A read only refills the latch when it is empty or being consumed this cycle.
   assign rd_issue = (mem_cnt != '0) && (!head_vld || out_ready) && !flush;

   assign out_valid = head_vld;
   assign out_data  = sram_o2;
   assign count     = mem_cnt + {{ADDR_W{1'b0}}, head_vld};

   assign sram_ce1  = clk;
   assign sram_ce2  = clk;
   assign sram_csb1 = !wr_fire;
   assign sram_web1 = sram_csb1;
   assign sram_a1   = wr_ptr;
   assign sram_i1   = in_data;
   assign sram_oeb1 = 1'b1;
   assign sram_csb2 = !rd_issue;
   assign sram_web2 = 1'b1;
   assign sram_a2   = rd_ptr;
   assign sram_oeb2 = 1'b0;

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         head_vld <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         head_vld <= 1'b0;
      end else begin
         if (wr_fire)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_issue)
            rd_ptr <= rd_ptr + 1'b1;

         case ({wr_fire, rd_issue})
            2'b10:   mem_cnt <= mem_cnt + 1'b1;
            2'b01:   mem_cnt <= mem_cnt - 1'b1;
            default: mem_cnt <= mem_cnt;
         endcase

         if (rd_issue)
            head_vld <= 1'b1;
         else if (pop)
            head_vld <= 1'b0;
      end
   end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Controller that turns one SRAM2RW16x16 dual-port macro into a 17-entry first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Port 1 of the macro is used for writes only; port 2 is used for reads only. The macro's port-2 output latch serves as the output register.
- Sits between a streaming producer and consumer in the lab datapath. The block owns all macro control pins.

Parameters:
- DATA_W, 16, word width; must match the macro word length.
- ADDR_W, 4, macro address width.
- DEPTH, 16, macro word count; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; also forwarded to sram_ce1 and sram_ce2.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear; takes priority over all handshakes.
- in_data  in  DATA_W  write data.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  DATA_W  head word; driven directly from sram_o2.
- out_valid  out  1  out_data holds a valid head word.
- out_ready  in  1  consumer accepts the head word.
- count  out  ADDR_W+1  total stored words, 0..DEPTH+1.
- sram_a1, sram_a2  out  ADDR_W  write and read addresses.
- sram_ce1, sram_ce2  out  1  driven equal to clk.
- sram_csb1, sram_csb2  out  1  active-low chip selects.
- sram_web1, sram_web2  out  1  sram_web1 = sram_csb1; sram_web2 is tied to 1.
- sram_oeb1, sram_oeb2  out  1  sram_oeb1 is tied to 1; sram_oeb2 is tied to 0.
- sram_i1  out  DATA_W  equals in_data.
- sram_o2  in  DATA_W  macro port-2 output.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: ADDR_W bits each; wrap from DEPTH-1 to 0 by natural overflow.
  - mem_cnt: 0..DEPTH, words resident in the macro.
  - head_vld: head word is present in the port-2 latch.
- Async reset (rst_n low) clears wr_ptr, rd_ptr, mem_cnt and head_vld to 0.
  - Outputs during and after reset: in_ready=1, out_valid=0, count=0, sram_csb1=1, sram_csb2=1.
  - Reset asserted mid-transfer drops all contents; no partial write is issued after deassertion.
- Write:
  - in_ready = (mem_cnt < DEPTH) and not flush.
  - wr_fire = in_valid and in_ready. wr_fire drives sram_csb1=0 and sram_a1=wr_ptr.
  - The macro captures the word at the same posedge; wr_ptr increments.
- Read issue:
  - rd_issue = (mem_cnt > 0) and (not head_vld or out_ready) and not flush.
  - rd_issue drives sram_csb2=0 and sram_a2=rd_ptr.
  - At that posedge: rd_ptr increments and head_vld is set to 1.
  - One-cycle read latency: the word appears on sram_o2/out_data after the edge.
- Pop:
  - pop = out_valid and out_ready.
  - If pop occurs without rd_issue, head_vld clears.
  - If pop and rd_issue coincide, head_vld stays 1 and the next word replaces the head at the edge, giving full throughput.
- out_valid = head_vld. out_data is stable while out_valid=1 and out_ready=0, because port 2 is deselected so the macro latch holds.
- mem_cnt update each cycle: +1 on wr_fire, -1 on rd_issue, unchanged when both occur.
- count = mem_cnt + head_vld.
- Collision avoidance:
  - A read is issued only when mem_cnt>0 before the edge.
  - A write is accepted only when mem_cnt<DEPTH.
  - Therefore rd_ptr never equals wr_ptr on a cycle with both rd_issue and wr_fire; no same-address read/write race in the macro.
- Full: count=17 means mem_cnt=16 and head_vld=1, so in_ready=0. A pop that cycle issues a read, and in_ready rises the following cycle.
- Empty: count=0, out_valid=0.
- Write into an empty FIFO:
  - Word written at edge N.
  - Read issued in cycle N+1, latching at edge N+1.
  - out_valid=1 after edge N+1, i.e. 2-cycle fall-through latency.
- Flush:
  - At the next edge, pointers, mem_cnt and head_vld clear.
  - in_ready=0 and no SRAM access occurs during the flush cycle.
  - Memory contents are not erased; they become stale.

Test Plan:
- Reset, then push 0x1111 at cycle 0 with out_ready=1 -> out_valid=1 with out_data=0x1111 two cycles later; count goes 0->1->1->0 after the pop.
- Push 0x0000..0x0010 (17 words) with out_ready=0 -> in_ready=0 after the 17th word, count=17, out_data=0x0000 held steady for 20 cycles.
- From full, hold out_ready=1 and in_valid=1 with an incrementing pattern for 64 cycles -> one pop per cycle, output in order with no gaps or duplicates, pointers wrap at least 3 times.
- Random in_valid/out_ready at 50% for 2000 cycles against a reference queue model -> exact data order match; assert sram_csb1=0 and sram_csb2=0 never coincide with sram_a1==sram_a2.
- With 5 words stored, assert flush for 1 cycle -> count=0, out_valid=0, in_ready=1 next cycle; pushing 0xBEEF then yields 0xBEEF as the first word out.
- Drop rst_n asynchronously mid-burst, between clock edges -> out_valid=0, count=0 and both chip selects high immediately; after release, normal operation resumes from empty.
